// File: rtl/ram_port_arbiter_if.sv
// ram_port_arbiter_if
//  Bundles the instruction requester, data requester and RAM port signals
//  that meet at the shared-RAM arbiter.
//  Parameter: NREQ - number of instruction requesters.
//  Signals:
//    iREN/iaddr        instruction read request and word address, per requester
//    iwait/iload       instruction stall and read data, per requester
//    dREN/dWEN/daddr   data read/write request and address
//    dstore            data write value
//    dwait/dload       data stall and read data
//    ramREN/ramWEN     RAM enables
//    ramaddr/ramstore  RAM address and write data
//    ramload/ramstate  RAM read data and status (FREE, BUSY, ACCESS, ERROR)
//  Modports: slave  - the arbiter
//            master - the requesters and the RAM model driving them
interface ram_port_arbiter_if #(parameter int NREQ = 2);
  logic [NREQ-1:0]        iREN;
  logic [NREQ-1:0][31:0]  iaddr;
  logic [NREQ-1:0]        iwait;
  logic [NREQ-1:0][31:0]  iload;
  logic                   dREN;
  logic                   dWEN;
  logic [31:0]            daddr;
  logic [31:0]            dstore;
  logic                   dwait;
  logic [31:0]            dload;
  logic                   ramREN;
  logic                   ramWEN;
  logic [31:0]            ramaddr;
  logic [31:0]            ramstore;
  logic [31:0]            ramload;
  logic [1:0]             ramstate;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );
endinterface

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
//  Shares one RAM port between NREQ instruction fetch requesters and one data
//  requester. The grant is registered and held until the owner's transaction
//  completes (owner request high while ramstate==ACCESS). Data has priority;
//  instruction requesters are served round-robin. Back-to-back grants are
//  decided on the completion cycle, so there is no idle cycle between them.
//  Parameters: NREQ (>=1), DSTREAK_MAX (1..7)
//  Ports:
//    CLK  - system clock, rising edge
//    RST  - asynchronous reset, active-high; abandons any transaction
//    bus  - ram_port_arbiter_if.slave (requester and RAM side signals)
//  Optional feature macro: RAM_ARB_STARVE_GUARD_EN
//    When defined, after DSTREAK_MAX consecutive data completions with an
//    instruction request pending, the round-robin instruction requester wins
//    one arbitration over data. When undefined, data priority is strict.
//
//  state | meaning
//  IDLE  | nobody owns the RAM port, ram* outputs 0
//  DGNT  | data requester owns the port
//  IGNT  | instruction requester gnt_idx owns the port
module ram_port_arbiter #(
  parameter int NREQ        = 2,
  parameter int DSTREAK_MAX = 4
) (
  input logic               CLK,
  input logic               RST,
  ram_port_arbiter_if.slave bus
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] DGNT = 2'd1;
  localparam logic [1:0] IGNT = 2'd2;

  // ramstate encoding: FREE=0, BUSY=1, ACCESS=2, ERROR=3
  localparam logic [1:0] RS_ACCESS = 2'd2;

  if (NREQ < 1 || DSTREAK_MAX < 1 || DSTREAK_MAX > 7) begin : g_bad_param
    $error("ram_port_arbiter: NREQ must be >= 1 and DSTREAK_MAX in 1..7");
  end

  logic [1:0]    state, state_nxt;
  logic [IW-1:0] gnt_idx, gnt_idx_nxt;
  logic [IW-1:0] rr_ptr, rr_ptr_nxt;
  logic [IW-1:0] scan_base, pick_idx;
  logic          pick_vld;
  logic          d_req, own_req, done, arb;
  logic          force_i;

  function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] v);
    if (int'(v) == NREQ - 1) return '0;
    return v + 1'b1;
  endfunction

  assign d_req = bus.dREN | bus.dWEN;

  always_comb begin
    own_req = 1'b0;
    case (state)
      DGNT:    own_req = d_req;
      IGNT:    own_req = bus.iREN[gnt_idx];
      default: own_req = 1'b0;
    endcase
  end

  assign done = own_req && (bus.ramstate == RS_ACCESS);
  // Re-arbitrate when idle, on completion, or when the owner abandons its request.
  assign arb  = done | ~own_req;

  // On an instruction completion the scan already starts past the finishing
  // requester, otherwise its still-high request would win again.
  assign scan_base = (state == IGNT && done) ? wrap_inc(gnt_idx) : rr_ptr;

  always_comb begin
    int            idx_i;
    logic [IW-1:0] idx;
    pick_vld = 1'b0;
    pick_idx = '0;
    idx_i    = 0;
    idx      = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx_i = int'(scan_base) + k;
      if (idx_i >= NREQ) idx_i = idx_i - NREQ;
      idx = IW'(idx_i);
      if (!pick_vld && bus.iREN[idx]) begin
        pick_vld = 1'b1;
        pick_idx = idx;
      end
    end
  end

`ifdef RAM_ARB_STARVE_GUARD_EN
  logic [2:0] streak, streak_eff, streak_nxt;

  // streak_eff already includes a data completion happening this cycle.
  assign streak_eff = (state == DGNT && done && (|bus.iREN) && streak != 3'd7)
                      ? streak + 3'd1 : streak;
  assign force_i    = pick_vld && (streak_eff == 3'(DSTREAK_MAX));

  always_comb begin
    streak_nxt = streak_eff;
    if (!(|bus.iREN))                    streak_nxt = '0;
    else if (arb && state_nxt == IGNT)   streak_nxt = '0;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) streak <= '0;
    else     streak <= streak_nxt;
  end
`else
  assign force_i = 1'b0;
`endif

  always_comb begin
    state_nxt   = state;
    gnt_idx_nxt = gnt_idx;
    rr_ptr_nxt  = rr_ptr;
    if (state == IGNT && done) rr_ptr_nxt = wrap_inc(gnt_idx);
    if (arb) begin
      if (d_req && !force_i) begin
        state_nxt = DGNT;
      end else if (pick_vld) begin
        state_nxt   = IGNT;
        gnt_idx_nxt = pick_idx;
      end else begin
        state_nxt = IDLE;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= IDLE;
      gnt_idx <= '0;
      rr_ptr  <= '0;
    end else begin
      state   <= state_nxt;
      gnt_idx <= gnt_idx_nxt;
      rr_ptr  <= rr_ptr_nxt;
    end
  end

  // Enables follow the owner's live request, so an abandoned request drops
  // the RAM enable in the same cycle.
  always_comb begin
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = '0;
    bus.ramstore = '0;
    bus.iwait    = '1;
    bus.iload    = '0;
    bus.dwait    = 1'b1;
    bus.dload    = '0;
    case (state)
      DGNT: begin
        bus.ramaddr  = bus.daddr;
        bus.ramWEN   = bus.dWEN;
        bus.ramREN   = bus.dREN & ~bus.dWEN;
        bus.ramstore = bus.dWEN ? bus.dstore : 32'h0;
        if (done) begin
          bus.dwait = 1'b0;
          bus.dload = bus.dWEN ? 32'h0 : bus.ramload;
        end
      end
      IGNT: begin
        bus.ramaddr = bus.iaddr[gnt_idx];
        bus.ramREN  = bus.iREN[gnt_idx];
        if (done) begin
          bus.iwait[gnt_idx] = 1'b0;
          bus.iload[gnt_idx] = bus.ramload;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter
//  Directed bench for ram_port_arbiter with NREQ=2, DSTREAK_MAX=4.
//  Covers reset (including mid-grant), round-robin fetch, data priority,
//  request abort, starvation guard (expectation follows
//  RAM_ARB_STARVE_GUARD_EN) and a stuck ERROR ramstate.
module tb_ram_port_arbiter;
  localparam int NREQ = 2;
  localparam logic [1:0] FREE   = 2'd0;
  localparam logic [1:0] BUSY   = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] ERROR  = 2'd3;

  logic        CLK = 1'b0;
  logic        RST;
  int          n_checks = 0;
  int          n_errors = 0;
  int          own;
  logic        iown;
  logic [31:0] v;

  ram_port_arbiter_if #(.NREQ(NREQ)) bus();

  ram_port_arbiter #(.NREQ(NREQ), .DSTREAK_MAX(4)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RST          = 1'b1;
    bus.iREN     = '0;
    bus.iaddr    = '0;
    bus.dREN     = 1'b0;
    bus.dWEN     = 1'b0;
    bus.daddr    = '0;
    bus.dstore   = '0;
    bus.ramload  = '0;
    bus.ramstate = FREE;
    step();
    step();
    check("rst_ramREN", bus.ramREN, 0);
    check("rst_ramWEN", bus.ramWEN, 0);
    check("rst_iwait",  bus.iwait, 2'b11);
    check("rst_dwait",  bus.dwait, 1);
    check("rst_dload",  bus.dload, 0);
    check("rst_iload",  bus.iload, 0);
    RST = 1'b0;
    step();

    // 1: reset while data write owns the port
    bus.dWEN = 1'b1; bus.daddr = 32'h40; bus.dstore = 32'h1234; #1;
    check("t1_idle_wen", bus.ramWEN, 0);
    step();
    check("t1_dgnt_wen",   bus.ramWEN, 1);
    check("t1_dgnt_addr",  bus.ramaddr, 32'h40);
    check("t1_dgnt_store", bus.ramstore, 32'h1234);
    RST = 1'b1; #1;
    check("t1_rst_wen",   bus.ramWEN, 0);
    check("t1_rst_dwait", bus.dwait, 1);
    check("t1_rst_iwait", bus.iwait, 2'b11);
    check("t1_rst_store", bus.ramstore, 0);
    bus.dWEN = 1'b0;
    step();
    RST = 1'b0;
    step();
    check("t1_post_en", {bus.ramREN, bus.ramWEN}, 0);

    // 2: round-robin 0,1,0,1 with ACCESS one cycle after each grant
    bus.iaddr[0] = 32'h10; bus.iaddr[1] = 32'h20; bus.iREN = 2'b11;
    bus.ramstate = BUSY; #1;
    check("t2_idle_ren", bus.ramREN, 0);
    for (int k = 0; k < 4; k++) begin
      own = k % 2;
      step();
      bus.ramstate = BUSY; #1;
      check("t2_addr",       bus.ramaddr, (own == 1) ? 32'h20 : 32'h10);
      check("t2_ren",        bus.ramREN, 1);
      check("t2_busy_iwait", bus.iwait, 2'b11);
      check("t2_busy_iload", bus.iload, 0);
      step();
      v = 32'hA000 + 32'(k);
      bus.ramstate = ACCESS; bus.ramload = v; #1;
      check("t2_acc_addr", bus.ramaddr, (own == 1) ? 32'h20 : 32'h10);
      check("t2_iwait",    bus.iwait, (own == 1) ? 2'b01 : 2'b10);
      check("t2_iload",    bus.iload, (own == 1) ? {v, 32'h0} : {32'h0, v});
    end
    step();
    bus.iREN = 2'b00; bus.ramstate = BUSY; #1;
    check("t2_drop_ren", bus.ramREN, 0);
    step();

    // 3: data arrives while instruction 0 is busy
    bus.iaddr[0] = 32'h30; bus.iREN = 2'b01;
    step();
    check("t3_iaddr", bus.ramaddr, 32'h30);
    bus.dWEN = 1'b1; bus.dREN = 1'b1; bus.daddr = 32'h100; bus.dstore = 32'hDEADBEEF; #1;
    check("t3_hold_addr",  bus.ramaddr, 32'h30);
    check("t3_hold_wen",   bus.ramWEN, 0);
    check("t3_hold_dwait", bus.dwait, 1);
    step();
    check("t3_hold2_addr", bus.ramaddr, 32'h30);
    bus.ramstate = ACCESS; bus.ramload = 32'h0BADF00D; #1;
    check("t3_i_done", bus.iwait, 2'b10);
    check("t3_dwait",  bus.dwait, 1);
    step();
    bus.iREN = 2'b00; bus.ramstate = BUSY; #1;
    check("t3_wen",   bus.ramWEN, 1);
    check("t3_ren",   bus.ramREN, 0);
    check("t3_addr",  bus.ramaddr, 32'h100);
    check("t3_store", bus.ramstore, 32'hDEADBEEF);
    check("t3_iwait", bus.iwait, 2'b11);
    check("t3_dwait_busy", bus.dwait, 1);
    bus.ramstate = ACCESS; bus.ramload = 32'h55; #1;
    check("t3_d_done",  bus.dwait, 0);
    check("t3_dload_wr", bus.dload, 0);
    step();
    bus.dWEN = 1'b0; bus.dREN = 1'b0; bus.ramstate = BUSY; #1;
    check("t3_drop_wen", bus.ramWEN, 0);
    step();

    // 4: abort of instruction 1 leaves rr_ptr at 1
    bus.iaddr[0] = 32'h10; bus.iaddr[1] = 32'h20; bus.iREN = 2'b11;
    step();
    check("t4_grant1", bus.ramaddr, 32'h20);
    check("t4_ren",    bus.ramREN, 1);
    bus.iREN = 2'b00; #1;
    check("t4_abort_ren",   bus.ramREN, 0);
    check("t4_abort_iwait", bus.iwait, 2'b11);
    step();
    check("t4_idle_ren", bus.ramREN, 0);
    bus.iREN = 2'b11;
    step();
    check("t4_rr_kept", bus.ramaddr, 32'h20);
    bus.ramstate = ACCESS; bus.ramload = 32'h4444; #1;
    check("t4_iwait", bus.iwait, 2'b01);
    check("t4_iload", bus.iload, {32'h4444, 32'h0});
    step();
    bus.iREN = 2'b00; bus.ramstate = BUSY;
    step();

    // 6: ERROR holds the data grant
    bus.dREN = 1'b1; bus.daddr = 32'h200; bus.ramstate = ERROR;
    step();
    for (int c = 0; c < 10; c++) begin
      check("t6_dwait", bus.dwait, 1);
      check("t6_addr",  bus.ramaddr, 32'h200);
      check("t6_ren",   bus.ramREN, 1);
      step();
    end
    bus.dREN = 1'b0; #1;
    check("t6_release_ren", bus.ramREN, 0);
    step();

    // 5: continuous data reads with instruction 0 pending
    bus.dREN = 1'b1; bus.daddr = 32'h300; bus.iREN = 2'b01; bus.iaddr[0] = 32'h10;
    bus.ramstate = ACCESS; bus.ramload = 32'h77;
    step();
    for (int c = 0; c < 6; c++) begin
`ifdef RAM_ARB_STARVE_GUARD_EN
      iown = (c == 4);
`else
      iown = 1'b0;
`endif
      check("t5_dwait", bus.dwait, iown);
      check("t5_dload", bus.dload, iown ? 32'h0 : 32'h77);
      check("t5_iwait", bus.iwait, iown ? 2'b10 : 2'b11);
      check("t5_addr",  bus.ramaddr, iown ? 32'h10 : 32'h300);
      step();
    end
    bus.dREN = 1'b0; bus.iREN = 2'b00; bus.ramstate = FREE;
    step();
    step();
    check("end_idle_en", {bus.ramREN, bus.ramWEN}, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
